cia_serial_port: RTL

- 6526-style serial data register (SDR) shift engine for the soc_65xx peripheral set; drives the SoC `sp_out`/`cnt_out` pins and consumes `sp_in`/`cnt_in`.
- Output mode: shifts a CPU-written byte out MSB-first, clocked by the timer A underflow pulse.
- Input mode: shifts `sp_in` in on rising edges of the external `cnt_in`.
- Raises a one-cycle interrupt pulse per completed byte to the ICR logic.

---
 rtl/soc_65xx_pkg.sv | 15 +
 rtl/cia_serial_port_if.sv | 29 ++
 rtl/sp_sync_edge.sv | 67 ++++++
 rtl/cia_serial_port.sv | 132 +++++++++++++
 4 files changed

// File: rtl/soc_65xx_pkg.sv
// Shared constants and types for the soc_65xx peripheral set.
package soc_65xx_pkg;

  localparam int unsigned SP_BITS  = 8;
  // Counter must be able to hold SP_BITS itself
  localparam int unsigned SP_CNT_W = $clog2(SP_BITS + 1);
  localparam logic        CNT_IDLE = 1'b1;

  typedef enum logic [1:0] {
    SP_IDLE,
    SP_SHIFT_LO,
    SP_SHIFT_HI
  } sp_state_t;

endpackage

// File: rtl/cia_serial_port_if.sv
// CPU-side register bus and serial pins of the 6526-style serial port.
interface cia_serial_port_if;
  import soc_65xx_pkg::*;

  logic               sdr_we;
  logic [SP_BITS-1:0] sdr_wdata;
  logic [SP_BITS-1:0] sdr_rdata;
  logic               spmode;
  logic               ta_underflow;
  logic               sp_in;
  logic               cnt_in;
  logic               sp_out;
  logic               cnt_out;
  logic               sp_irq;
  logic               busy;

  // Driver side: CPU, timer and external pin drivers
  modport master (
    output sdr_we, sdr_wdata, spmode, ta_underflow, sp_in, cnt_in,
    input  sdr_rdata, sp_out, cnt_out, sp_irq, busy
  );

  // Serial port side
  modport slave (
    input  sdr_we, sdr_wdata, spmode, ta_underflow, sp_in, cnt_in,
    output sdr_rdata, sp_out, cnt_out, sp_irq, busy
  );

endinterface

// File: rtl/sp_sync_edge.sv
// Synchroniser and rising-edge detector for the external serial clock, with the
// serial data pin delayed by the same depth so data and clock stay aligned.
// Depth: 2 flops when SP_SYNC2_EN is defined, 1 flop otherwise.
module sp_sync_edge
  import soc_65xx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_cnt,
  input  logic i_sp,
  output logic o_cnt_rise,
  output logic o_sp_sync
);

  logic w_cnt_s;
  logic w_sp_s;
  logic r_cnt_prev;

`ifdef SP_SYNC2_EN
  logic [1:0] r_cnt_sync;
  logic [1:0] r_sp_sync;

  // Two-stage synchroniser on both pins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_sync <= {2{CNT_IDLE}};
      r_sp_sync  <= {2{CNT_IDLE}};
    end else begin
      r_cnt_sync <= {r_cnt_sync[0], i_cnt};
      r_sp_sync  <= {r_sp_sync[0], i_sp};
    end
  end

  assign w_cnt_s = r_cnt_sync[1];
  assign w_sp_s  = r_sp_sync[1];
`else
  logic r_cnt_sync;
  logic r_sp_sync;

  // Single input register on both pins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_sync <= CNT_IDLE;
      r_sp_sync  <= CNT_IDLE;
    end else begin
      r_cnt_sync <= i_cnt;
      r_sp_sync  <= i_sp;
    end
  end

  assign w_cnt_s = r_cnt_sync;
  assign w_sp_s  = r_sp_sync;
`endif

  // Edge register; reset to idle-high so a pin resting high gives no edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_prev <= CNT_IDLE;
    end else begin
      r_cnt_prev <= w_cnt_s;
    end
  end

  assign o_cnt_rise = w_cnt_s & ~r_cnt_prev;
  assign o_sp_sync  = w_sp_s;

endmodule

// File: rtl/cia_serial_port.sv
// 6526-style serial data register shift engine.
// Output mode shifts SDR out MSB-first on timer A underflows (2 per bit);
// input mode shifts sp_in in on synchronised rising edges of cnt_in.
// Optional macro SP_SYNC2_EN selects a 2-flop input synchroniser (see sp_sync_edge).
module cia_serial_port
  import soc_65xx_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  cia_serial_port_if.slave         sp_bus
);

  logic [SP_BITS-1:0]  r_sdr_reg;
  logic [SP_BITS-1:0]  r_shift_reg;
  logic [SP_CNT_W-1:0] r_bit_cnt;
  logic                r_pending;
  sp_state_t           r_state;
  logic                r_sp_out;
  logic                r_cnt_out;
  logic                r_sp_irq;
  logic                r_spmode;

  logic                w_cnt_rise;
  logic                w_sp_sync;
  logic [SP_BITS-1:0]  w_shift_in;
  logic                w_last_bit;

  sp_sync_edge u_sync (
    .clk        (clk),
    .reset      (reset),
    .i_cnt      (sp_bus.cnt_in),
    .i_sp       (sp_bus.sp_in),
    .o_cnt_rise (w_cnt_rise),
    .o_sp_sync  (w_sp_sync)
  );

  assign w_shift_in = {r_shift_reg[SP_BITS-2:0], w_sp_sync};
  assign w_last_bit = (r_bit_cnt == SP_CNT_W'(SP_BITS - 1));

  // Shift engine: mode-change abort, output FSM and input shifter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sdr_reg   <= '0;
      r_shift_reg <= '0;
      r_bit_cnt   <= '0;
      r_pending   <= 1'b0;
      r_state     <= SP_IDLE;
      r_sp_out    <= CNT_IDLE;
      r_cnt_out   <= CNT_IDLE;
      r_sp_irq    <= 1'b0;
      // Track the live mode so leaving reset never looks like a mode change
      r_spmode    <= sp_bus.spmode;
    end else begin
      r_sp_irq <= 1'b0;
      r_spmode <= sp_bus.spmode;
      if (sp_bus.spmode != r_spmode) begin
        // Mode change aborts any transfer; SDR contents survive
        r_state   <= SP_IDLE;
        r_bit_cnt <= '0;
        r_pending <= 1'b0;
        r_cnt_out <= CNT_IDLE;
        r_sp_out  <= CNT_IDLE;
        if (sp_bus.sdr_we) begin
          r_sdr_reg <= sp_bus.sdr_wdata;
        end
      end else if (r_spmode) begin
        if (sp_bus.ta_underflow) begin
          case (r_state)
            SP_IDLE: begin
              if (r_pending) begin
                r_shift_reg <= r_sdr_reg;
                r_pending   <= 1'b0;
                r_bit_cnt   <= '0;
                r_cnt_out   <= 1'b0;
                r_sp_out    <= r_sdr_reg[SP_BITS-1];
                r_state     <= SP_SHIFT_HI;
              end
            end
            SP_SHIFT_HI: begin
              r_cnt_out   <= 1'b1;
              r_shift_reg <= {r_shift_reg[SP_BITS-2:0], 1'b0};
              if (w_last_bit) begin
                r_sp_irq  <= 1'b1;
                r_bit_cnt <= '0;
                r_state   <= SP_IDLE;
              end else begin
                r_bit_cnt <= r_bit_cnt + SP_CNT_W'(1);
                r_state   <= SP_SHIFT_LO;
              end
            end
            SP_SHIFT_LO: begin
              r_cnt_out <= 1'b0;
              r_sp_out  <= r_shift_reg[SP_BITS-1];
              r_state   <= SP_SHIFT_HI;
            end
            default: r_state <= SP_IDLE;
          endcase
        end
        // Placed after the FSM so a write on a reload cycle stays pending
        if (sp_bus.sdr_we) begin
          r_sdr_reg <= sp_bus.sdr_wdata;
          r_pending <= 1'b1;
        end
      end else begin
        r_cnt_out <= CNT_IDLE;
        r_sp_out  <= CNT_IDLE;
        if (sp_bus.sdr_we) begin
          r_sdr_reg <= sp_bus.sdr_wdata;
        end
        // Received byte is assigned last so it wins over a same-cycle CPU write
        if (w_cnt_rise) begin
          r_shift_reg <= w_shift_in;
          if (w_last_bit) begin
            r_sdr_reg <= w_shift_in;
            r_sp_irq  <= 1'b1;
            r_bit_cnt <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + SP_CNT_W'(1);
          end
        end
      end
    end
  end

  assign sp_bus.sdr_rdata = r_sdr_reg;
  assign sp_bus.sp_out    = r_sp_out;
  assign sp_bus.cnt_out   = r_cnt_out;
  assign sp_bus.sp_irq    = r_sp_irq;
  assign sp_bus.busy      = r_spmode ? ((r_state != SP_IDLE) | r_pending)
                                     : (r_bit_cnt != '0);

endmodule
